// File: rtl/ber_phase_ctrl.sv
// Sequencing controller for the QPSK BER loop: symbol strobe generation and
// an rx sampling-phase sweep that locks onto the phase with the fewest errors.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for start after reset
// S_SETTLE  | ignoring syms while the tx/rx pipeline refills after a phase change
// S_MEASURE | counting error_flag over the measurement window
// S_EVAL    | one cycle: update best phase, advance phase or finish
// S_LOCK    | phase_out held at the winning phase; start re-arms a sweep
module ber_phase_ctrl #(
  parameter int OS           = 4,
  parameter int STROBE_PHASE = 1,
  parameter int SETTLE_SYM   = 32,
  parameter int WINDOW_SYM   = 1024,
  parameter int ERR_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             error_flag,
  output logic             enable_prbs,
  output logic             enable_ber,
  output logic             enable_tx,
  output logic             enable_rx,
  output logic [1:0]       phase_out,
  output logic             busy,
  output logic             done,
  output logic [1:0]       best_phase,
  output logic [ERR_W-1:0] best_errors
);

  localparam int DIV_W   = (OS > 1) ? $clog2(OS) : 1;
  localparam int SYM_MAX = (SETTLE_SYM > WINDOW_SYM) ? SETTLE_SYM : WINDOW_SYM;
  localparam int CNT_W   = (SYM_MAX > 1) ? $clog2(SYM_MAX) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(OS - 1);
  localparam logic [DIV_W-1:0] STB_CNT   = DIV_W'(STROBE_PHASE);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_SYM - 1);
  localparam logic [CNT_W-1:0] WINDOW_LD = CNT_W'(WINDOW_SYM - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_MEASURE,
    S_EVAL,
    S_LOCK
  } state_t;

  state_t           state, state_nxt;
  logic [DIV_W-1:0] div_cnt;
  logic             stb;
  logic             en_txrx;
  logic [CNT_W-1:0] sym_cnt, sym_cnt_nxt;
  logic [ERR_W-1:0] err_cnt, err_cnt_nxt;
  logic [1:0]       phase_nxt, best_phase_nxt;
  logic [ERR_W-1:0] best_errors_nxt;
  logic             busy_nxt, done_nxt;

  // Divider and strobe run regardless of sweep state.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      stb     <= 1'b0;
      en_txrx <= 1'b0;
    end else begin
      div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
      stb     <= (div_cnt == STB_CNT);
      en_txrx <= 1'b1;
    end
  end

  assign enable_prbs = stb;
  assign enable_ber  = stb;
  assign enable_tx   = en_txrx;
  assign enable_rx   = en_txrx;

  always_comb begin
    state_nxt       = state;
    sym_cnt_nxt     = sym_cnt;
    err_cnt_nxt     = err_cnt;
    phase_nxt       = phase_out;
    best_phase_nxt  = best_phase;
    best_errors_nxt = best_errors;
    busy_nxt        = busy;
    done_nxt        = 1'b0;

    case (state)
      S_IDLE, S_LOCK: begin
        if (start) begin
          state_nxt       = S_SETTLE;
          phase_nxt       = 2'd0;
          busy_nxt        = 1'b1;
          best_errors_nxt = '1;
          sym_cnt_nxt     = SETTLE_LD;
          err_cnt_nxt     = '0;
        end
      end

      S_SETTLE: begin
        if (stb) begin
          if (sym_cnt == '0) begin
            state_nxt   = S_MEASURE;
            sym_cnt_nxt = WINDOW_LD;
            err_cnt_nxt = '0;
          end else begin
            sym_cnt_nxt = sym_cnt - CNT_W'(1);
          end
        end
      end

      S_MEASURE: begin
        if (stb) begin
          if (error_flag && (err_cnt != '1))
            err_cnt_nxt = err_cnt + ERR_W'(1);
          if (sym_cnt == '0)
            state_nxt = S_EVAL;
          else
            sym_cnt_nxt = sym_cnt - CNT_W'(1);
        end
      end

      S_EVAL: begin
        // Strict compare keeps the lower phase on a tie.
        if ((phase_out == 2'd0) || (err_cnt < best_errors)) begin
          best_phase_nxt  = phase_out;
          best_errors_nxt = err_cnt;
        end
        if (phase_out == 2'd3) begin
          state_nxt = S_LOCK;
          phase_nxt = best_phase_nxt;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
        end else begin
          state_nxt   = S_SETTLE;
          phase_nxt   = phase_out + 2'd1;
          sym_cnt_nxt = SETTLE_LD;
          err_cnt_nxt = '0;
        end
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      sym_cnt     <= '0;
      err_cnt     <= '0;
      phase_out   <= 2'd0;
      best_phase  <= 2'd0;
      best_errors <= '1;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_nxt;
      sym_cnt     <= sym_cnt_nxt;
      err_cnt     <= err_cnt_nxt;
      phase_out   <= phase_nxt;
      best_phase  <= best_phase_nxt;
      best_errors <= best_errors_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
    end
  end

endmodule

// File: tb/tb_ber_phase_ctrl.sv
// Bench for ber_phase_ctrl: sweep-level reference model compared every cycle,
// plus literal checks of strobe timing, sweep results and reset behaviour.
module tb_ber_phase_ctrl;

  localparam int OS      = 4;
  localparam int SP      = 1;
  localparam int S       = 2;
  localparam int W       = 8;
  localparam int ERR_W   = 16;
  localparam int PER     = S + W;
  localparam int ERR_MAX = (1 << ERR_W) - 1;

  logic             clk, rst, start, error_flag, error_flag3;
  logic             enable_prbs, enable_ber, enable_tx, enable_rx, busy, done;
  logic [1:0]       phase_out, best_phase;
  logic [ERR_W-1:0] best_errors;

  logic             e3_prbs, e3_ber, e3_tx, e3_rx, busy3, done3;
  logic [1:0]       phase_out3, best_phase3;
  logic [2:0]       best_errors3;

  ber_phase_ctrl #(.OS(OS), .STROBE_PHASE(SP), .SETTLE_SYM(S), .WINDOW_SYM(W), .ERR_W(ERR_W)) u_dut (
    .clk(clk), .rst(rst), .start(start), .error_flag(error_flag),
    .enable_prbs(enable_prbs), .enable_ber(enable_ber), .enable_tx(enable_tx), .enable_rx(enable_rx),
    .phase_out(phase_out), .busy(busy), .done(done), .best_phase(best_phase), .best_errors(best_errors)
  );

  ber_phase_ctrl #(.OS(OS), .STROBE_PHASE(SP), .SETTLE_SYM(S), .WINDOW_SYM(W), .ERR_W(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start), .error_flag(error_flag3),
    .enable_prbs(e3_prbs), .enable_ber(e3_ber), .enable_tx(e3_tx), .enable_rx(e3_rx),
    .phase_out(phase_out3), .busy(busy3), .done(done3), .best_phase(best_phase3), .best_errors(best_errors3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: sweep described by sym index k; phase = k/PER, offset
  // k%PER, offsets >= S are measured. The edge after the last measured sym
  // of a phase is the evaluation edge.
  int               m_n, m_k, p_m, o_m, bp_m;
  int               m_errs[4];
  logic             m_stb, m_tx, m_busy, m_done, m_eval, was_busy, sym_m;
  logic [1:0]       m_phase, m_bphase;
  logic [ERR_W-1:0] m_berr;

  always @(posedge clk) begin
    if (rst) begin
      m_n = 0; m_k = 0; m_stb = 0; m_tx = 0; m_busy = 0; m_done = 0; m_eval = 0;
      m_phase = 0; m_bphase = 0; m_berr = '1;
      for (int i = 0; i < 4; i++) m_errs[i] = 0;
    end else begin
      was_busy = m_busy;
      sym_m    = m_stb;
      m_done   = 0;
      if (m_eval) begin
        p_m  = int'(m_phase);
        bp_m = 0;
        for (int i = 1; i <= p_m; i++) if (m_errs[i] < m_errs[bp_m]) bp_m = i;
        m_bphase = 2'(bp_m);
        m_berr   = ERR_W'(m_errs[bp_m]);
        m_eval   = 0;
        if (p_m == 3) begin
          m_done = 1; m_busy = 0; m_phase = m_bphase;
        end else begin
          m_phase = 2'(p_m + 1);
        end
      end else if (was_busy && sym_m) begin
        p_m = m_k / PER;
        o_m = m_k % PER;
        if (o_m >= S && error_flag && m_errs[p_m] < ERR_MAX) m_errs[p_m]++;
        if (o_m == PER - 1) m_eval = 1;
        m_k++;
      end
      if (!was_busy && start) begin
        m_busy = 1; m_phase = 0; m_berr = '1; m_k = 0;
        for (int i = 0; i < 4; i++) m_errs[i] = 0;
      end
      m_n++;
      m_stb = (((m_n - 1) % OS) == SP);
      m_tx  = 1;
    end
  end

  bit chk_en = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("enable_prbs", enable_prbs, m_stb);
      chk("enable_ber",  enable_ber,  m_stb);
      chk("enable_tx",   enable_tx,   m_tx);
      chk("enable_rx",   enable_rx,   m_tx);
      chk("phase_out",   phase_out,   m_phase);
      chk("busy",        busy,        m_busy);
      chk("done",        done,        m_done);
      chk("best_phase",  best_phase,  m_bphase);
      chk("best_errors", best_errors, m_berr);
    end
  end

  // Stimulus
  int emode;
  int tgt[4];
  int inj[4];

  function automatic bit meas_sym_next();
    return m_busy && !m_eval && m_stb && ((m_k % PER) >= S);
  endfunction

  task automatic drive();
    bit ms;
    int p;
    ms = meas_sym_next();
    p  = m_k / PER;
    start = 1'b0;
    case (emode)
      0: error_flag = 1'b0;
      1: begin
        error_flag = 1'b0;
        if (ms && p < 4) begin
          if (inj[p] < tgt[p]) begin
            error_flag = 1'b1;
            inj[p]++;
          end
        end
      end
      2: error_flag = !ms;
      default: begin
        error_flag = ($urandom_range(0, 2) == 0);
        if (m_busy && $urandom_range(0, 7) == 0) start = 1'b1;
      end
    endcase
  endtask

  task automatic run_sweep(input int mode, input string tag);
    bit seen;
    seen  = 0;
    emode = mode;
    for (int i = 0; i < 4; i++) inj[i] = 0;
    drive();
    start = 1'b1;
    for (int i = 0; i < 1000 && !seen; i++) begin
      @(negedge clk);
      drive();
      if (done) seen = 1;
    end
    chk({tag, "_done_seen"}, 32'(seen), 1);
  endtask

  initial begin
    bit hit;
    rst = 1'b1; start = 1'b0; error_flag = 1'b0; error_flag3 = 1'b1; emode = 0;
    repeat (2) @(negedge clk);
    chk_en = 1;
    rst = 1'b0;

    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      chk("t1_strobe", enable_ber, (c == 2 || c == 6 || c == 10) ? 1 : 0);
      chk("t1_tx", enable_tx, 1);
      chk("t1_rx", enable_rx, 1);
      chk("t1_phase", phase_out, 0);
      chk("t1_busy", busy, 0);
      chk("t1_done", done, 0);
    end

    run_sweep(0, "t2");
    chk("t2_best_phase", best_phase, 0);
    chk("t2_best_errors", best_errors, 0);
    chk("t2_phase_out", phase_out, 0);
    chk("t2_busy", busy, 0);
    chk("t5_best_phase3", best_phase3, 0);
    chk("t5_best_errors3", best_errors3, 7);

    tgt = '{5, 2, 7, 2};
    run_sweep(1, "t3");
    chk("t3_best_phase", best_phase, 1);
    chk("t3_best_errors", best_errors, 2);
    chk("t3_phase_out", phase_out, 1);
    chk("t5_best_errors3_b", best_errors3, 7);

    run_sweep(2, "t4");
    chk("t4_best_phase", best_phase, 0);
    chk("t4_best_errors", best_errors, 0);

    repeat (3) run_sweep(3, "rnd");
    chk("t5_best_phase3_c", best_phase3, 0);
    chk("t5_best_errors3_c", best_errors3, 7);

    // reset in the middle of the phase-2 measurement window
    emode = 3;
    drive();
    start = 1'b1;
    hit = 0;
    for (int i = 0; i < 1000 && !hit; i++) begin
      @(negedge clk);
      drive();
      if (m_busy && m_k >= 2 * PER + S + 2) hit = 1;
    end
    chk("t6_reached_phase2", 32'(hit), 1);
    chk("t6_phase_before_rst", phase_out, 2);
    rst = 1'b1; start = 1'b0;
    @(negedge clk);
    chk("t6_rst_ber", enable_ber, 0);
    chk("t6_rst_tx", enable_tx, 0);
    chk("t6_rst_phase", phase_out, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_done", done, 0);
    chk("t6_rst_best_phase", best_phase, 0);
    chk("t6_rst_best_errors", best_errors, 32'hffff);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    run_sweep(0, "t6_after");
    chk("t6_best_phase", best_phase, 0);
    chk("t6_best_errors", best_errors, 0);
    chk("t6_busy", busy, 0);

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
